// File: rtl/wb_decoder_fifo_if.sv
// Wishbone slave feeding an instruction FIFO to an external combinational decoder.
// The decoder result is read back as NRES 32-bit words; sticky flags report FIFO errors.
module wb_decoder_fifo_if #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          INSTR_W    = 8,
    parameter int          RESULT_W   = 66,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [INSTR_W-1:0]  head_instr_o,
    output logic                head_valid_o,
    input  logic                head_ready_i,
    input  logic [RESULT_W-1:0] result_i
);
    localparam int NRES = (RESULT_W + 31) / 32;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [29:0] NWORDS = 30'(3 + NRES);

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic [INSTR_W-1:0]  mem_q [FIFO_DEPTH];
    logic [INSTR_W-1:0]  mem_d [FIFO_DEPTH];

    logic [29:0]         word;
    logic                in_win, acc, wr_acc;
    logic [PW-1:0]       count;
    logic                empty, full;
    logic                push_req, ctrl_wr, flush, pop_bus, clr_err, hw_pop;
    logic                do_pop, do_push, ovf_set, unf_set;
    logic [32*NRES-1:0]  res_pad;
    logic [31:0]         rdata;

    // Word index relative to the window; addresses below BASE wrap to large values.
    assign word   = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign in_win = (word < NWORDS);
    assign acc    = wbs_cyc_i & wbs_stb_i & in_win & ~ack_q;
    assign wr_acc = acc & wbs_we_i;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(FIFO_DEPTH));

    assign head_valid_o = ~empty;
    assign head_instr_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;

    always_comb begin
        push_req = wr_acc & (word == 30'd0) & wbs_sel_i[0];
        ctrl_wr  = wr_acc & (word == 30'd1);
        pop_bus  = ctrl_wr & wbs_dat_i[0];
        flush    = ctrl_wr & wbs_dat_i[1];
        clr_err  = ctrl_wr & wbs_dat_i[2];
        hw_pop   = ~empty & head_ready_i;
        // Bus and hardware pop merge into a single removal; flush overrides both.
        do_pop   = (pop_bus | hw_pop) & ~empty & ~flush;
        do_push  = push_req & (~full | do_pop);
        ovf_set  = push_req & full & ~do_pop;
        unf_set  = pop_bus & empty & ~flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wbs_dat_i[INSTR_W-1:0];
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        unf_d = (unf_q & ~clr_err) | unf_set;
    end

    always_comb begin
        res_pad = '0;
        res_pad[RESULT_W-1:0] = result_i;
        rdata = '0;
        if (word == 30'd0) begin
            rdata[INSTR_W-1:0] = head_instr_o;
        end else if (word == 30'd2) begin
            rdata[0]    = empty;
            rdata[1]    = full;
            rdata[2]    = ovf_q;
            rdata[3]    = unf_q;
            rdata[15:8] = 8'(count);
        end else begin
            for (int k = 0; k < NRES; k++) begin
                if (word == 30'(3 + k) && !empty) begin
                    rdata = res_pad[32*k +: 32];
                end
            end
        end
        ack_d = acc;
        dat_d = (acc & ~wbs_we_i) ? rdata : dat_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; the head output is masked while the FIFO is empty.
    always_ff @(posedge wb_clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_wb_decoder_fifo_if.sv
// Directed bench for wb_decoder_fifo_if: register map, FIFO corner cases,
// hardware/bus pop interaction, out-of-window accesses and reset mid-access.
module tb_wb_decoder_fifo_if;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  head_instr;
    logic        head_valid;
    logic        head_ready = 1'b0;
    logic [65:0] result = 66'h3_CAFE_F00D_1234_5678;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic        acked;

    wb_decoder_fifo_if #(
        .BASE_ADDR(BASE), .INSTR_W(8), .RESULT_W(66), .FIFO_DEPTH(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .head_instr_o(head_instr), .head_valid_o(head_valid),
        .head_ready_i(head_ready), .result_i(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] off;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(string n, logic w, logic [31:0] o,
                                 logic [31:0] d, logic [3:0] s, logic [31:0] e);
        vec_t v;
        v.name = n; v.we = w; v.off = o; v.wd = d; v.sel = s; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; waits up to 10 cycles for ack, then one idle cycle.
    task automatic bus(input logic w, input logic [31:0] off, input logic [31:0] wd,
                       input logic [3:0] s, output logic [31:0] r, output logic a);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + off; dat_i = wd; sel = s;
        a = 1'b0; r = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                a = 1'b1;
                r = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input string n, input logic [31:0] off, input logic [31:0] d);
        bus(1'b1, off, d, 4'hF, rd, acked);
        chk({n, " ack"}, 32'(acked), 32'd1);
    endtask

    task automatic rdchk(input string n, input logic [31:0] off, input logic [31:0] e);
        bus(1'b0, off, 32'h0, 4'hF, rd, acked);
        chk({n, " ack"}, 32'(acked), 32'd1);
        chk(n, rd, e);
    endtask

    logic [7:0] fill_vals [8];

    initial begin
        fill_vals = '{8'hA9, 8'h00, 8'hEA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66};

        addv("st_reset",   1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0001);
        addv("instr_rst",  1'b0, 32'h00, 32'h0,         4'hF, 32'h0);
        addv("res0_empty", 1'b0, 32'h0C, 32'h0,         4'hF, 32'h0);
        addv("push_a9",    1'b1, 32'h00, 32'hFFFF_FFA9, 4'hF, 32'h0);
        addv("push_00",    1'b1, 32'h00, 32'h0000_0000, 4'hF, 32'h0);
        addv("push_ea",    1'b1, 32'h00, 32'h0000_00EA, 4'hF, 32'h0);
        addv("st_cnt3",    1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0300);
        addv("instr_head", 1'b0, 32'h00, 32'h0,         4'hF, 32'h0000_00A9);
        addv("res0",       1'b0, 32'h0C, 32'h0,         4'hF, 32'h1234_5678);
        addv("res1",       1'b0, 32'h10, 32'h0,         4'hF, 32'hCAFE_F00D);
        addv("res2",       1'b0, 32'h14, 32'h0,         4'hF, 32'h0000_0003);
        addv("ctrl_read",  1'b0, 32'h04, 32'h0,         4'hF, 32'h0);
        addv("st_ro_wr",   1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0);
        addv("st_after_ro",1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0300);
        for (int i = 3; i < 8; i++)
            addv("push_fill", 1'b1, 32'h00, 32'(fill_vals[i]), 4'hF, 32'h0);
        addv("st_full",    1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0802);
        addv("push_ovf",   1'b1, 32'h00, 32'h0000_0055, 4'hF, 32'h0);
        addv("st_ovf",     1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0806);
        addv("clr_err",    1'b1, 32'h04, 32'h0000_0004, 4'hF, 32'h0);
        addv("st_clr",     1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0802);

        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_head_valid", 32'(head_valid), 32'd0);
        chk("rst_head_instr", 32'(head_instr), 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);

        // Ack lasts one cycle even with the strobe held.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h08; sel = 4'hF;
        @(posedge clk); #1;
        chk("ack_first", 32'(ack), 32'd1);
        chk("ack_first_dat", dat_o, 32'h0000_0001);
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].we, tbl[i].off, tbl[i].wd, tbl[i].sel, rd, acked);
            chk({tbl[i].name, " ack"}, 32'(acked), 32'd1);
            if (!tbl[i].we) chk(tbl[i].name, rd, tbl[i].exp);
        end

        // Drain in order; the dropped 0x55 must not appear.
        for (int i = 0; i < 8; i++) begin
            rdchk($sformatf("drain_head%0d", i), 32'h00, 32'(fill_vals[i]));
            wr("drain_pop", 32'h04, 32'h1);
        end
        rdchk("st_drained", 32'h08, 32'h0000_0001);
        wr("pop_empty", 32'h04, 32'h1);
        rdchk("st_unf", 32'h08, 32'h0000_0009);
        wr("clr_unf", 32'h04, 32'h4);

        // Flush with pop on a full FIFO.
        for (int i = 0; i < 8; i++) wr("refill", 32'h00, 32'(fill_vals[i]));
        rdchk("st_refull", 32'h08, 32'h0000_0802);
        wr("flush_pop", 32'h04, 32'h3);
        rdchk("st_flushed", 32'h08, 32'h0000_0001);
        bus(1'b1, 32'h00, 32'h0000_0077, 4'b1110, rd, acked);
        chk("sel0_low ack", 32'(acked), 32'd1);
        rdchk("st_no_push", 32'h08, 32'h0000_0001);

        // Hardware pop coinciding with a bus POP removes one entry.
        for (int i = 0; i < 3; i++) wr("push_hw", 32'h00, 32'(fill_vals[i]));
        chk("hw_head0", 32'(head_instr), 32'h0000_00A9);
        chk("hw_valid0", 32'(head_valid), 32'd1);
        head_ready = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; dat_i = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        chk("hw_bus_pop ack", 32'(ack), 32'd1);
        head_ready = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("hw_head1", 32'(head_instr), 32'h0000_0000);
        rdchk("st_hw_cnt2", 32'h08, 32'h0000_0200);
        head_ready = 1'b1;
        @(posedge clk); #1;
        chk("hw_head2", 32'(head_instr), 32'h0000_00EA);
        @(posedge clk); #1;
        chk("hw_empty_valid", 32'(head_valid), 32'd0);
        chk("hw_empty_instr", 32'(head_instr), 32'd0);
        @(posedge clk); #1;
        head_ready = 1'b0;
        rdchk("st_hw_empty", 32'h08, 32'h0000_0001);
        wr("pop_empty2", 32'h04, 32'h1);
        rdchk("st_unf2", 32'h08, 32'h0000_0009);

        // Out-of-window accesses are never acknowledged.
        bus(1'b0, 32'h40, 32'h0, 4'hF, rd, acked);
        chk("oow_0x40 ack", 32'(acked), 32'd0);
        bus(1'b1, 32'h18, 32'h0, 4'hF, rd, acked);
        chk("oow_0x18 ack", 32'(acked), 32'd0);

        // Reset during a pending access clears everything and suppresses the ack.
        wr("push_pre_rst", 32'h00, 32'h0000_0077);
        rdchk("st_pre_rst", 32'h08, 32'h0000_0108);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h08; sel = 4'hF;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_ack", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", 32'(ack), 32'd0);
        chk("post_rst_dat", dat_o, 32'd0);
        chk("post_rst_valid", 32'(head_valid), 32'd0);
        chk("post_rst_instr", 32'(head_instr), 32'd0);
        rdchk("st_post_rst", 32'h08, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_decoder_fifo_if.md
Name: wb_decoder_fifo_if

Overview:
Parametrised Wishbone slave and successor to the single-register decoder interface. Firmware writes a queue of opcodes into an instruction FIFO. The FIFO head drives an external (combinational) instruction decoder through a valid/ready port. The wide decoder result is read back over as many 32-bit words as needed. Sticky status flags report FIFO state and errors. Sits in the user project area between the Wishbone bus and the decoder.

Parameters:
BASE_ADDR, 32'h3000_0000, word-aligned base of the register window
INSTR_W, 8, instruction width (1..32)
RESULT_W, 66, decoder result width (1..128); NRES = ceil(RESULT_W/32) result words
FIFO_DEPTH, 8, instruction FIFO entries; power of two, 2..64

Ports:
wb_clk_i  in  1  bus/system clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge, registered
wbs_dat_o  out  32  read data, registered
head_instr_o  out  INSTR_W  FIFO head instruction to decoder (0 when empty)
head_valid_o  out  1  FIFO non-empty
head_ready_i  in  1  decoder consumes head when high with head_valid_o
result_i  in  RESULT_W  decoder result for head_instr_o

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 INSTR: W pushes wbs_dat_i[INSTR_W-1:0], only if wbs_sel_i[0]=1. R returns head zero-extended (0 if empty).
  - 0x04 CTRL (W only; reads 0): bit0 POP, bit1 FLUSH, bit2 CLR_ERR.
  - 0x08 STATUS (R only): [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [15:8] count.
  - 0x0C + 4k, k=0..NRES-1: RESULT[k] = result_i[32k+31:32k]. Bits above RESULT_W read 0. Whole word reads 0 when FIFO empty.
- Decode window: BASE_ADDR .. BASE_ADDR+0x0C+4*(NRES-1). wbs_adr_i[1:0] ignored.
- Handshake:
  - Access valid when cyc & stb & in-window & !wbs_ack_o.
  - wbs_ack_o pulses high for exactly one cycle, the cycle after a valid access. Minimum 2 cycles per access; no back-to-back ack.
  - wbs_dat_o is loaded on the same edge that sets ack and holds until the next read.
  - Writes to read-only registers and reads of CTRL are acked with no side effect.
  - Out-of-window accesses are never acked.
- Side effects apply on the edge that sets ack.
- FIFO: DEPTH entries, pointers with one extra wrap bit; count 0..DEPTH.
  - Push when full: data dropped, overflow set.
  - POP when empty: underflow set, no change.
  - Hardware pop: head_valid_o & head_ready_i.
  - Bus POP and hardware pop in the same cycle remove exactly one entry.
  - Push and pop in the same cycle: count unchanged, both pointers advance. When full, push+pop succeeds (no overflow).
  - FLUSH empties the FIFO. FLUSH wins over POP and over a hardware pop in the same cycle.
  - CLR_ERR clears both sticky flags. A new error in the same cycle wins (flag stays set).
- Reset (async assert, sync release): ack=0, dat_o=0, FIFO empty, pointers 0, flags 0, head_instr_o=0, head_valid_o=0. Reset mid-transaction aborts it with no ack.

Test Plan:
- Reset, then read STATUS -> 0x0000_0001. Read INSTR -> 0. Read RESULT[0] -> 0. Ack is exactly one cycle.
- Write INSTR 0xA9, 0x00, 0xEA -> STATUS count=3. head_instr_o=0xA9. RESULT words equal result_i slices; RESULT[2] upper 30 bits are 0.
- Fill with DEPTH=8 writes, then a 9th write 0x55 -> full=1, overflow=1, count=8, 0x55 absent. CLR_ERR clears overflow, full stays 1.
- With head_ready_i=1 held and a simultaneous bus POP -> exactly one entry removed per cycle. Order preserved 0xA9→0x00→0xEA. Extra POP when empty -> underflow=1.
- Full FIFO, write FLUSH|POP -> count=0, empty=1, no underflow. Write INSTR with wbs_sel_i=4'b1110 -> acked, no push.
- Read at BASE_ADDR+0x40 -> no ack within 10 cycles. Assert wb_rst_ni low during a pending access -> ack stays 0, all state cleared.
